// File: rtl/note_sequencer_if.sv
// Keyboard-to-tone-generator bus for the note sequencer.
// Carries the decoded note/octave and key levels in, and the sounding note and buffer status out.
// master: keyboard decode side (drives keys, observes status); slave: the sequencer itself.
interface note_sequencer_if #(
  parameter int ADDR_W = 5
);
  // keyboard decode -> sequencer
  logic [3:0]      note_in;     // 0 = rest, 1..12 = A..G#
  logic [1:0]      octave_in;
  logic            load_n;      // low while load key held
  logic            playback_n;  // low while playback key held
  logic            clear;       // single-cycle pulse, empties the buffer

  // sequencer -> tone generator / status
  logic [3:0]      note_out;
  logic [1:0]      octave_out;
  logic            note_valid;
  logic            busy;
  logic            full;
  logic [ADDR_W:0] count;

  modport master (
    output note_in, octave_in, load_n, playback_n, clear,
    input  note_out, octave_out, note_valid, busy, full, count
  );

  modport slave (
    input  note_in, octave_in, load_n, playback_n, clear,
    output note_out, octave_out, note_valid, busy, full, count
  );
endinterface

// File: rtl/note_sequencer.sv
// Records note/octave presses into a buffer and replays them with fixed note and gap durations.
// Latency: playback press at edge E -> FETCH after E, note_valid from E+2; each entry takes 1+NOTE_TICKS+GAP_TICKS cycles.
// No backpressure: key presses are edge-detected levels; presses that cannot be honoured are dropped.
//
// Ports:
//   clock, resetn : system clock, asynchronous active-low reset
//   bus (slave)   : note_in/octave_in/load_n/playback_n/clear in;
//                   note_out/octave_out/note_valid/busy/full/count out
module note_sequencer #(
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int NOTE_TICKS = 25000000,
  parameter int GAP_TICKS  = 2500000
) (
  input  logic            clock,
  input  logic            resetn,
  note_sequencer_if.slave bus
);

  localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TIMER_W   = $clog2(MAX_TICKS + 1);
  localparam int CNT_W     = ADDR_W + 1;

  localparam logic [TIMER_W-1:0] NOTE_LOAD = TIMER_W'(NOTE_TICKS - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [ADDR_W-1:0]  rd_idx;
  logic [TIMER_W-1:0] timer;

  // Previous-cycle key levels; reset to 0 so a key held through reset
  // never looks like a fresh press.
  logic               load_hist;
  logic               play_hist;

  logic [3:0]         note_q;
  logic [1:0]         octave_q;
  logic               valid_q;
  logic               busy_q;

  logic [5:0]         mem [DEPTH];
  logic [5:0]         rd_data;

  logic               load_press;
  logic               play_press;
  logic               full;
  logic               wr_en;
  logic               last_entry;

  assign load_press = ~bus.load_n & load_hist;
  assign play_press = ~bus.playback_n & play_hist;
  assign full       = (count == FULL_CNT);

  // Recording is only possible from IDLE with room left; clear wins over everything.
  assign wr_en      = (state == IDLE) & load_press & ~full & ~bus.clear;

  assign last_entry = ({1'b0, rd_idx} == (count - 1'b1));

  // Record buffer: synchronous write, registered read issued only in FETCH
  // so rd_data is stable for the whole note.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[count[ADDR_W-1:0]] <= {bus.octave_in, bus.note_in};
    end
    if (state == FETCH) begin
      rd_data <= mem[rd_idx];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      count     <= '0;
      rd_idx    <= '0;
      timer     <= '0;
      load_hist <= 1'b0;
      play_hist <= 1'b0;
      note_q    <= '0;
      octave_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      load_hist <= bus.load_n;
      play_hist <= bus.playback_n;

      if (bus.clear) begin
        state   <= IDLE;
        count   <= '0;
        rd_idx  <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else if ((state != IDLE) && play_press) begin
        // Stop request: silence immediately; a restart needs a fresh press.
        state   <= IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            valid_q <= 1'b0;
            if (load_press) begin
              // A load press always shadows a simultaneous playback press,
              // even when the buffer is full and the load itself is dropped.
              if (wr_en) begin
                count <= count + 1'b1;
              end
            end else if (play_press && (count != '0)) begin
              state  <= FETCH;
              rd_idx <= '0;
              busy_q <= 1'b1;
            end
          end

          FETCH: begin
            state <= HOLD;
            timer <= NOTE_LOAD;
          end

          HOLD: begin
            // Read data lands at HOLD entry, so the output stage trails the
            // state by one cycle; note_valid still spans NOTE_TICKS cycles.
            note_q   <= rd_data[3:0];
            octave_q <= rd_data[5:4];
            valid_q  <= 1'b1;
            if (timer == '0) begin
              state <= GAP;
              timer <= GAP_LOAD;
            end else begin
              timer <= timer - 1'b1;
            end
          end

          GAP: begin
            valid_q <= 1'b0;
            if (timer == '0) begin
              if (last_entry) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                state  <= FETCH;
                rd_idx <= rd_idx + 1'b1;
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end

          default: begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.note_out   = note_q;
  assign bus.octave_out = octave_q;
  assign bus.note_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.full       = full;
  assign bus.count      = count;

endmodule
